// File: rtl/tile_fp_stream_alu.sv
// Pipelined floating-point add/sub/accumulate on joined AXI-stream operands.
// Three register stages (unpack/align, add, normalise/pack); the last stage is the output register.
module tile_fp_stream_alu #(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int BW    = 1 + EXP_W + MAN_W,
    parameter  int CNT_W = 16
) (
    input  logic             clk_line,
    input  logic             clk_line_rst_high,
    input  logic [1:0]       op_mode,
    input  logic             in_a_TVALID,
    output logic             in_a_TREADY,
    input  logic [BW-1:0]    in_a_TDATA,
    input  logic             in_a_TLAST,
    input  logic             in_b_TVALID,
    output logic             in_b_TREADY,
    input  logic [BW-1:0]    in_b_TDATA,
    output logic             out_TVALID,
    input  logic             out_TREADY,
    output logic [BW-1:0]    out_TDATA,
    output logic             out_TLAST,
    output logic             busy,
    output logic [CNT_W-1:0] beat_count,
    output logic [CNT_W-1:0] ovf_count
);

    typedef enum logic [1:0] {M_ADD = 2'd0, M_SUB = 2'd1, M_ACC = 2'd2, M_RSV = 2'd3} mode_t;

    localparam int SW  = MAN_W + 2;
    localparam int EW2 = EXP_W + 2;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [BW-1:0]    QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [BW-1:0]    NEG_ZERO = {1'b1, {(BW-1){1'b0}}};

    mode_t r_mode;
    logic  r_in_pkt;
    logic [BW-1:0] r_acc;
    logic [CNT_W-1:0] r_beat_cnt, r_ovf_cnt;

    logic r1_valid, r1_sign, r1_sub, r1_zsign, r1_spec, r1_last, r1_emit, r1_acc;
    logic [EXP_W-1:0] r1_exp;
    logic [MAN_W:0] r1_mbig, r1_msmall;
    logic [BW-1:0] r1_spec_val;

    logic r2_valid, r2_sign, r2_zsign, r2_spec, r2_last, r2_emit, r2_acc;
    logic [EXP_W-1:0] r2_exp;
    logic [SW-1:0] r2_sum;
    logic [BW-1:0] r2_spec_val;

    logic r3_valid, r3_ovf, r3_last, r3_emit, r3_acc;
    logic [BW-1:0] r3_data;

    mode_t w_mode;
    logic w_is_acc, w_is_sub, w_o_valid, w_en1, w_en2, w_en3, w_empty, w_join, w_fire, w_out_hs;
    logic [BW-1:0] w_op_b;

    // A packet keeps the mode seen on its first beat; between packets op_mode is live.
    assign w_mode    = r_in_pkt ? r_mode : mode_t'(op_mode);
    assign w_is_acc  = (w_mode == M_ACC);
    assign w_is_sub  = (w_mode == M_SUB);
    assign w_o_valid = r3_valid & r3_emit;
    assign w_en3     = !r3_valid | !r3_emit | out_TREADY;
    assign w_en2     = !r2_valid | w_en3;
    assign w_en1     = !r1_valid | w_en2;
    assign w_empty   = !r1_valid & !r2_valid & !r3_valid;
    assign w_join    = in_a_TVALID & in_b_TVALID & w_en1;
    assign in_a_TREADY = w_is_acc ? w_empty : w_join;
    assign in_b_TREADY = w_is_acc ? 1'b0 : w_join;
    assign w_fire    = in_a_TVALID & in_a_TREADY;
    assign w_out_hs  = w_o_valid & out_TREADY;

    // Adding -0 to the first ACC beat passes A through unchanged, including signed zeros.
    always_comb begin
        w_op_b = in_b_TDATA;
        if (w_is_acc)
            w_op_b = r_in_pkt ? r_acc : NEG_ZERO;
        else if (w_is_sub)
            w_op_b = {~in_b_TDATA[BW-1], in_b_TDATA[BW-2:0]};
    end

    logic w_sa, w_sb, w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_swap, w_spec;
    logic [EXP_W-1:0] w_ea, w_eb, w_big_exp, w_small_exp, w_ediff;
    logic [MAN_W:0] w_ma, w_mb, w_big_man, w_small_man, w_small_al;
    logic [BW-1:0] w_spec_val;

    always_comb begin
        w_sa    = in_a_TDATA[BW-1];
        w_sb    = w_op_b[BW-1];
        w_a_nan = (in_a_TDATA[BW-2:MAN_W] == EXP_ONES) && (in_a_TDATA[MAN_W-1:0] != '0);
        w_b_nan = (w_op_b[BW-2:MAN_W] == EXP_ONES) && (w_op_b[MAN_W-1:0] != '0);
        w_a_inf = (in_a_TDATA[BW-2:MAN_W] == EXP_ONES) && (in_a_TDATA[MAN_W-1:0] == '0);
        w_b_inf = (w_op_b[BW-2:MAN_W] == EXP_ONES) && (w_op_b[MAN_W-1:0] == '0);
        w_ea    = in_a_TDATA[BW-2:MAN_W];
        w_eb    = w_op_b[BW-2:MAN_W];
        w_ma    = (w_ea == '0) ? '0 : {1'b1, in_a_TDATA[MAN_W-1:0]};
        w_mb    = (w_eb == '0) ? '0 : {1'b1, w_op_b[MAN_W-1:0]};
        w_swap  = {w_eb, w_mb} > {w_ea, w_ma};
        w_big_exp   = w_swap ? w_eb : w_ea;
        w_small_exp = w_swap ? w_ea : w_eb;
        w_big_man   = w_swap ? w_mb : w_ma;
        w_small_man = w_swap ? w_ma : w_mb;
        w_ediff     = w_big_exp - w_small_exp;
        w_small_al  = (int'(w_ediff) > MAN_W + 1) ? '0 : (w_small_man >> w_ediff);
        w_spec      = 1'b0;
        w_spec_val  = '0;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_sa != w_sb))) begin
            w_spec     = 1'b1;
            w_spec_val = QNAN;
        end else if (w_a_inf || w_b_inf) begin
            w_spec     = 1'b1;
            w_spec_val = {(w_a_inf ? w_sa : w_sb), EXP_ONES, {MAN_W{1'b0}}};
        end
    end

    always_ff @(posedge clk_line or posedge clk_line_rst_high) begin
        if (clk_line_rst_high) begin
            r1_valid <= 1'b0; r1_sign <= 1'b0; r1_sub <= 1'b0; r1_zsign <= 1'b0;
            r1_exp <= '0; r1_mbig <= '0; r1_msmall <= '0; r1_spec <= 1'b0;
            r1_spec_val <= '0; r1_last <= 1'b0; r1_emit <= 1'b0; r1_acc <= 1'b0;
        end else if (w_en1) begin
            r1_valid <= w_fire;
            if (w_fire) begin
                r1_sign     <= w_swap ? w_sb : w_sa;
                r1_sub      <= w_sa ^ w_sb;
                r1_zsign    <= w_sa & w_sb;
                r1_exp      <= w_big_exp;
                r1_mbig     <= w_big_man;
                r1_msmall   <= w_small_al;
                r1_spec     <= w_spec;
                r1_spec_val <= w_spec_val;
                r1_last     <= w_is_acc | in_a_TLAST;
                r1_emit     <= !w_is_acc | in_a_TLAST;
                r1_acc      <= w_is_acc;
            end
        end
    end

    always_ff @(posedge clk_line or posedge clk_line_rst_high) begin
        if (clk_line_rst_high) begin
            r2_valid <= 1'b0; r2_sum <= '0; r2_sign <= 1'b0; r2_zsign <= 1'b0; r2_exp <= '0;
            r2_spec <= 1'b0; r2_spec_val <= '0; r2_last <= 1'b0; r2_emit <= 1'b0; r2_acc <= 1'b0;
        end else if (w_en2) begin
            r2_valid <= r1_valid;
            if (r1_valid) begin
                r2_sum      <= r1_sub ? ({1'b0, r1_mbig} - {1'b0, r1_msmall})
                                      : ({1'b0, r1_mbig} + {1'b0, r1_msmall});
                r2_sign     <= r1_sign;
                r2_zsign    <= r1_zsign;
                r2_exp      <= r1_exp;
                r2_spec     <= r1_spec;
                r2_spec_val <= r1_spec_val;
                r2_last     <= r1_last;
                r2_emit     <= r1_emit;
                r2_acc      <= r1_acc;
            end
        end
    end

    int w_msb;
    logic signed [EW2-1:0] w_lz, w_exp_adj;
    logic [SW-1:0] w_norm;
    logic [MAN_W-1:0] w_man;
    logic [BW-1:0] w_res;
    logic w_res_ovf;

    // Magnitude is never negative because S1 ordered the operands by size.
    always_comb begin
        w_msb = 0;
        for (int i = 0; i <= MAN_W; i++)
            if (r2_sum[i]) w_msb = i;
        w_lz      = EW2'(MAN_W - w_msb);
        w_norm    = r2_sum << w_lz;
        w_exp_adj = $signed({2'b00, r2_exp}) - w_lz;
        w_man     = w_norm[MAN_W-1:0];
        w_res     = '0;
        w_res_ovf = 1'b0;
        if (r2_sum[SW-1]) begin
            w_exp_adj = $signed({2'b00, r2_exp}) + EW2'(1);
            w_man     = r2_sum[MAN_W:1];
        end
        if (r2_spec)
            w_res = r2_spec_val;
        else if (r2_sum == '0)
            w_res = {r2_zsign, {(BW-1){1'b0}}};
        else if (w_exp_adj >= $signed({2'b00, EXP_ONES})) begin
            w_res     = {r2_sign, EXP_ONES, {MAN_W{1'b0}}};
            w_res_ovf = 1'b1;
        end else if (w_exp_adj <= 0)
            w_res = {r2_sign, {(BW-1){1'b0}}};
        else
            w_res = {r2_sign, w_exp_adj[EXP_W-1:0], w_man};
    end

    always_ff @(posedge clk_line or posedge clk_line_rst_high) begin
        if (clk_line_rst_high) begin
            r3_valid <= 1'b0; r3_data <= '0; r3_ovf <= 1'b0;
            r3_last <= 1'b0; r3_emit <= 1'b0; r3_acc <= 1'b0;
        end else if (w_en3) begin
            r3_valid <= r2_valid;
            if (r2_valid) begin
                r3_data <= w_res;
                r3_ovf  <= w_res_ovf;
                r3_last <= r2_last;
                r3_emit <= r2_emit;
                r3_acc  <= r2_acc;
            end
        end
    end

    // Non-final ACC sums sit in S3 for one cycle without out_TVALID, then fold into the accumulator.
    always_ff @(posedge clk_line or posedge clk_line_rst_high) begin
        if (clk_line_rst_high) begin
            r_mode     <= M_ADD;
            r_in_pkt   <= 1'b0;
            r_acc      <= '0;
            r_beat_cnt <= '0;
            r_ovf_cnt  <= '0;
        end else begin
            if (w_fire) begin
                if (!r_in_pkt) r_mode <= mode_t'(op_mode);
                r_in_pkt <= !in_a_TLAST;
            end
            if (r3_valid && r3_acc && !r3_emit)
                r_acc <= r3_data;
            if (w_out_hs) begin
                if (r_beat_cnt != '1) r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                if (r3_ovf && (r_ovf_cnt != '1)) r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
            end
        end
    end

    assign out_TVALID = w_o_valid;
    assign out_TDATA  = r3_data;
    assign out_TLAST  = r3_last;
    assign busy       = r1_valid | r2_valid | r3_valid | (r_in_pkt & (r_mode == M_ACC));
    assign beat_count = r_beat_cnt;
    assign ovf_count  = r_ovf_cnt;

endmodule

// File: tb/tb_tile_fp_stream_alu.sv
// Directed self-checking bench for tile_fp_stream_alu (binary32 format).
module tb_tile_fp_stream_alu;

   logic        clk_line = 1'b0;
   logic        clk_line_rst_high;
   logic [1:0]  op_mode;
   logic        in_a_TVALID, in_a_TREADY, in_a_TLAST;
   logic [31:0] in_a_TDATA;
   logic        in_b_TVALID, in_b_TREADY;
   logic [31:0] in_b_TDATA;
   logic        out_TVALID, out_TREADY, out_TLAST, busy;
   logic [31:0] out_TDATA;
   logic [15:0] beat_count, ovf_count;

   tile_fp_stream_alu dut (
      .clk_line(clk_line), .clk_line_rst_high(clk_line_rst_high), .op_mode(op_mode),
      .in_a_TVALID(in_a_TVALID), .in_a_TREADY(in_a_TREADY), .in_a_TDATA(in_a_TDATA),
      .in_a_TLAST(in_a_TLAST), .in_b_TVALID(in_b_TVALID), .in_b_TREADY(in_b_TREADY),
      .in_b_TDATA(in_b_TDATA), .out_TVALID(out_TVALID), .out_TREADY(out_TREADY),
      .out_TDATA(out_TDATA), .out_TLAST(out_TLAST), .busy(busy),
      .beat_count(beat_count), .ovf_count(ovf_count)
   );

   // 10 ns line clock
   always #5 clk_line = ~clk_line;

   typedef struct {
      logic [1:0]  mode;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [15:0] ovfInc;
   } vec_t;

   int total = 0;
   int bad = 0;
   logic [31:0] resQ[$];
   logic        lastQ[$];
   bit sawStall, sawReadySplit, sawBReady;

   // Record output handshakes and ready behaviour between clock edges
   always @(negedge clk_line) begin
      #2;
      if (out_TVALID && out_TREADY) begin
         resQ.push_back(out_TDATA);
         lastQ.push_back(out_TLAST);
      end
      if (in_a_TVALID && !in_a_TREADY) sawStall = 1'b1;
      if (in_a_TREADY != in_b_TREADY) sawReadySplit = 1'b1;
      if (in_b_TREADY) sawBReady = 1'b1;
   end

   // Hard stop in case something hangs outside the bounded waits
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
      end
   endtask

   // Present one joined beat at a negedge and wait (bounded) for its acceptance
   task automatic applyStimulus(input logic [1:0] mode, input logic [31:0] a, input logic [31:0] b,
                                input logic last);
      int waitCyc = 0;
      op_mode = mode;
      in_a_TDATA = a;
      in_b_TDATA = b;
      in_a_TLAST = last;
      in_a_TVALID = 1'b1;
      in_b_TVALID = 1'b1;
      #1;
      while (!in_a_TREADY && waitCyc < 40) begin
         @(negedge clk_line);
         #1;
         waitCyc++;
      end
      checkOutput("accept", {31'd0, in_a_TREADY}, 32'd1);
      if (in_a_TREADY) @(posedge clk_line);
      @(negedge clk_line);
      in_a_TVALID = 1'b0;
      in_b_TVALID = 1'b0;
   endtask

   task automatic waitResults(input int n);
      int waitCyc = 0;
      while (resQ.size() < n && waitCyc < 60) begin
         @(negedge clk_line);
         waitCyc++;
      end
      @(negedge clk_line);
      #1;
      checkOutput("result count", resQ.size(), n);
   endtask

   vec_t vecs[14];
   logic [31:0] bVals[8];
   logic [31:0] sumVals[8];
   logic [15:0] beatBefore, ovfBefore;
   logic [31:0] got;

   initial begin
      vecs[0]  = '{2'd0, 32'h3F800000, 32'h40000000, 32'h40400000, 16'd0};
      vecs[1]  = '{2'd1, 32'h3F800000, 32'h3F800000, 32'h00000000, 16'd0};
      vecs[2]  = '{2'd0, 32'h80000000, 32'h80000000, 32'h80000000, 16'd0};
      vecs[3]  = '{2'd0, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 16'd0};
      vecs[4]  = '{2'd0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 16'd1};
      vecs[5]  = '{2'd1, 32'h40400000, 32'h3F800000, 32'h40000000, 16'd0};
      vecs[6]  = '{2'd0, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 16'd0};
      vecs[7]  = '{2'd0, 32'h7F800000, 32'h3F800000, 32'h7F800000, 16'd0};
      vecs[8]  = '{2'd0, 32'h00400000, 32'h80000000, 32'h00000000, 16'd0};
      vecs[9]  = '{2'd3, 32'h3F800000, 32'h40000000, 32'h40400000, 16'd0};
      vecs[10] = '{2'd0, 32'h4C000000, 32'h3F800000, 32'h4C000000, 16'd0};
      vecs[11] = '{2'd1, 32'h00C00000, 32'h00800000, 32'h00000000, 16'd0};
      vecs[12] = '{2'd0, 32'h3F800000, 32'hC0000000, 32'hBF800000, 16'd0};
      vecs[13] = '{2'd0, 32'hFF800000, 32'h40A00000, 32'hFF800000, 16'd0};
      bVals   = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                  32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
      sumVals = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                  32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};

      clk_line_rst_high = 1'b1;
      op_mode = 2'd0;
      in_a_TVALID = 1'b0; in_a_TDATA = '0; in_a_TLAST = 1'b0;
      in_b_TVALID = 1'b0; in_b_TDATA = '0;
      out_TREADY = 1'b1;
      repeat (2) @(negedge clk_line);
      #1;
      checkOutput("reset out_TVALID", {31'd0, out_TVALID}, 32'd0);
      checkOutput("reset out_TDATA", out_TDATA, 32'd0);
      checkOutput("reset out_TLAST", {31'd0, out_TLAST}, 32'd0);
      checkOutput("reset busy", {31'd0, busy}, 32'd0);
      checkOutput("reset beat_count", {16'd0, beat_count}, 32'd0);
      checkOutput("reset ovf_count", {16'd0, ovf_count}, 32'd0);
      clk_line_rst_high = 1'b0;
      @(negedge clk_line);

      // Latency: result visible after the third edge counting the accept edge
      resQ.delete(); lastQ.delete();
      applyStimulus(2'd0, 32'h3F800000, 32'h40000000, 1'b1);
      #1;
      checkOutput("latency valid e0", {31'd0, out_TVALID}, 32'd0);
      checkOutput("latency busy", {31'd0, busy}, 32'd1);
      @(negedge clk_line); #1;
      checkOutput("latency valid e1", {31'd0, out_TVALID}, 32'd0);
      @(negedge clk_line); #1;
      checkOutput("latency valid e2", {31'd0, out_TVALID}, 32'd1);
      checkOutput("latency data", out_TDATA, 32'h40400000);
      @(negedge clk_line); #1;
      checkOutput("latency beat_count", {16'd0, beat_count}, 32'd1);

      // Single-beat vectors
      for (int i = 0; i < 14; i++) begin
         resQ.delete(); lastQ.delete();
         beatBefore = beat_count;
         ovfBefore = ovf_count;
         applyStimulus(vecs[i].mode, vecs[i].a, vecs[i].b, 1'b1);
         waitResults(1);
         got = (resQ.size() > 0) ? resQ[0] : 32'hxxxxxxxx;
         checkOutput($sformatf("vec%0d data", i), got, vecs[i].res);
         checkOutput($sformatf("vec%0d last", i), (lastQ.size() > 0) ? {31'd0, lastQ[0]} : 32'hx, 32'd1);
         checkOutput($sformatf("vec%0d beat inc", i), {16'd0, beat_count - beatBefore}, 32'd1);
         checkOutput($sformatf("vec%0d ovf inc", i), {16'd0, ovf_count - ovfBefore}, {16'd0, vecs[i].ovfInc});
      end
      checkOutput("ovf_count total", {16'd0, ovf_count}, 32'd1);

      // Accumulate packet; op_mode changes after the first beat must be ignored
      resQ.delete(); lastQ.delete();
      sawBReady = 1'b0;
      applyStimulus(2'd2, 32'h3F800000, 32'h12345678, 1'b0);
      #1;
      checkOutput("acc busy", {31'd0, busy}, 32'd1);
      applyStimulus(2'd0, 32'h40000000, 32'h12345678, 1'b0);
      applyStimulus(2'd0, 32'h40400000, 32'h12345678, 1'b0);
      applyStimulus(2'd0, 32'h40800000, 32'h12345678, 1'b1);
      waitResults(1);
      got = (resQ.size() > 0) ? resQ[0] : 32'hxxxxxxxx;
      checkOutput("acc sum", got, 32'h41200000);
      checkOutput("acc last", (lastQ.size() > 0) ? {31'd0, lastQ[0]} : 32'hx, 32'd1);
      checkOutput("acc b ready seen", {31'd0, sawBReady}, 32'd0);

      // Eight back-to-back beats with downstream stalled in cycles 2-7
      resQ.delete(); lastQ.delete();
      sawStall = 1'b0;
      sawReadySplit = 1'b0;
      fork
         begin
            for (int i = 0; i < 8; i++)
               applyStimulus(2'd0, 32'h3F800000, bVals[i], (i == 7));
         end
         begin
            for (int c = 0; c < 12; c++) begin
               out_TREADY = !(c >= 2 && c <= 7);
               @(negedge clk_line);
            end
            out_TREADY = 1'b1;
         end
      join
      waitResults(8);
      for (int i = 0; i < 8; i++) begin
         got = (resQ.size() > i) ? resQ[i] : 32'hxxxxxxxx;
         checkOutput($sformatf("stream%0d data", i), got, sumVals[i]);
         checkOutput($sformatf("stream%0d last", i), (lastQ.size() > i) ? {31'd0, lastQ[i]} : 32'hx,
                     (i == 7) ? 32'd1 : 32'd0);
      end
      checkOutput("stream stall seen", {31'd0, sawStall}, 32'd1);
      checkOutput("stream ready split", {31'd0, sawReadySplit}, 32'd0);

      // Reset with beats in flight, then a clean beat
      resQ.delete(); lastQ.delete();
      out_TREADY = 1'b0;
      applyStimulus(2'd0, 32'h3F800000, 32'h40000000, 1'b1);
      applyStimulus(2'd0, 32'h40000000, 32'h40000000, 1'b1);
      @(negedge clk_line);
      #1;
      checkOutput("pre-reset out_TVALID", {31'd0, out_TVALID}, 32'd1);
      clk_line_rst_high = 1'b1;
      #1;
      checkOutput("mid reset out_TVALID", {31'd0, out_TVALID}, 32'd0);
      checkOutput("mid reset beat_count", {16'd0, beat_count}, 32'd0);
      checkOutput("mid reset ovf_count", {16'd0, ovf_count}, 32'd0);
      checkOutput("mid reset busy", {31'd0, busy}, 32'd0);
      @(negedge clk_line);
      clk_line_rst_high = 1'b0;
      out_TREADY = 1'b1;
      @(negedge clk_line);
      applyStimulus(2'd0, 32'h40400000, 32'h3F800000, 1'b1);
      waitResults(1);
      repeat (5) @(negedge clk_line);
      #1;
      checkOutput("post reset count", resQ.size(), 32'd1);
      got = (resQ.size() > 0) ? resQ[0] : 32'hxxxxxxxx;
      checkOutput("post reset data", got, 32'h40800000);
      checkOutput("post reset beat_count", {16'd0, beat_count}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
